// File: rtl/voxel_column_sequencer.sv
// Renders the voxel volume into the framebuffer: one front-to-back z scan per (x,y) column and
// one shaded pixel write per column, sharing the framebuffer write port with a CPU requester.
module voxel_column_sequencer #(
    parameter int unsigned GRID_BITS = 3,
    parameter logic [11:0] FB_BASE   = 12'h000,
    parameter int unsigned FB_STRIDE = 64,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   vblank,
    output logic                   vox_rd,
    output logic [3*GRID_BITS-1:0] vox_addr,
    input  logic                   vox_q,
    input  logic                   cpu_req,
    input  logic [11:0]            cpu_addr,
    input  logic [7:0]             cpu_data,
    output logic                   cpu_gnt,
    output logic                   we,
    output logic [11:0]            addr,
    output logic [7:0]             ram_d,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned          ShadeShift = 8 - GRID_BITS;
    localparam logic [GRID_BITS-1:0] AxisMax    = '1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [GRID_BITS-1:0] x_q, x_d;
    logic [GRID_BITS-1:0] y_q, y_d;
    logic [GRID_BITS-1:0] z_q, z_d;
    logic [7:0]           pix_q, pix_d;

    logic                   vox_rd_q, vox_rd_d;
    logic [3*GRID_BITS-1:0] vox_addr_q, vox_addr_d;
    logic                   cpu_gnt_q, cpu_gnt_d;
    logic                   we_q, we_d;
    logic [11:0]            addr_q, addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic        cpu_win;
    logic        seq_fire;
    logic        last_col;
    logic [11:0] seq_addr;
    logic [7:0]  shade;

    // Nearer voxels are brighter: depth occupies the top GRID_BITS bits of the pixel.
    always_comb begin
        shade    = 8'hFF - (8'(z_q) << ShadeShift);
        seq_addr = 12'(32'(FB_BASE) + 32'(y_q) * FB_STRIDE + 32'(x_q));
        last_col = (x_q == AxisMax) && (y_q == AxisMax);
    end

    // The CPU is refused in its grant cycle so a held request yields exactly one write.
    always_comb begin
        cpu_win = vblank && cpu_req && !cpu_gnt_q;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        pix_d    = pix_q;
        busy_d   = busy_q;
        seq_fire = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    z_d     = '0;
                    busy_d  = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StWait;
            end
            StWait: begin
                if (vox_q) begin
                    pix_d   = shade;
                    state_d = StWrite;
                end else if (z_q == AxisMax) begin
                    pix_d   = BG_COLOR;
                    state_d = StWrite;
                end else begin
                    z_d     = z_q + 1'b1;
                    state_d = StRead;
                end
            end
            StWrite: begin
                if (vblank && !cpu_win) begin
                    seq_fire = 1'b1;
                    z_d      = '0;
                    x_d      = x_q + 1'b1;
                    if (x_q == AxisMax) begin
                        y_d = y_q + 1'b1;
                    end
                    state_d = last_col ? StDone : StRead;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        we_d       = cpu_win || seq_fire;
        cpu_gnt_d  = cpu_win;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        if (cpu_win) begin
            addr_d    = cpu_addr;
            wr_data_d = cpu_data;
        end else if (seq_fire) begin
            addr_d    = seq_addr;
            wr_data_d = pix_q;
        end
        vox_rd_d   = (state_d == StRead);
        vox_addr_d = vox_rd_d ? {x_d, y_d, z_d} : vox_addr_q;
        done_d     = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            pix_q      <= '0;
            vox_rd_q   <= 1'b0;
            vox_addr_q <= '0;
            cpu_gnt_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            pix_q      <= pix_d;
            vox_rd_q   <= vox_rd_d;
            vox_addr_q <= vox_addr_d;
            cpu_gnt_q  <= cpu_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign vox_rd   = vox_rd_q;
    assign vox_addr = vox_addr_q;
    assign cpu_gnt  = cpu_gnt_q;
    assign we       = we_q;
    assign addr     = addr_q;
    assign ram_d    = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

    a_we_needs_vblank : assert property (@(posedge clk) disable iff (reset) we |-> $past(vblank));
    a_gnt_is_write    : assert property (@(posedge clk) disable iff (reset) cpu_gnt |-> we);
    a_done_not_busy   : assert property (@(posedge clk) disable iff (reset) done |-> !busy);

endmodule
